// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the AXI4 crossbar arbiters (read and write side).
// Holds the per-slave arbiter state encoding and the slave port numbering.
// Imported by axi_rd_slave_arbiter and the AW/W/B arbiter.
package axi_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int NUM_SLAVES = 8;

  // Slave port numbering used by the address decoder one-hot hit vector.
  localparam int SLV_ROM     = 0;
  localparam int SLV_UART    = 1;
  localparam int SLV_IRQ     = 2;
  localparam int SLV_MTIME   = 3;
  localparam int SLV_RST     = 4;
  localparam int SLV_MMU     = 5;
  localparam int SLV_RAMCTRL = 6;
  localparam int SLV_RAM     = 7;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit scanning from ptr upward, modulo NUM_MASTERS.
// Purely combinational, zero latency; shared by read- and write-side arbiters.
// Ports: req (request vector), ptr (scan start) -> pick (one-hot), pick_idx (binary), any (|req).
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [IDX_W-1:0]       pick_idx,
  output logic                   any
);

  // One extra bit so ptr + offset (< 2*NUM_MASTERS) never overflows before the wrap.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_MASTERS)) begin
        sum = sum - (IDX_W+1)'(NUM_MASTERS);
      end
      idx = sum[IDX_W-1:0];
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axi_rd_slave_arbiter.sv
// Per-slave AR/R arbiter: round-robin grant held from AR handshake through RLAST, with watchdog.
// Ports: ACLK/ARESETn; req per master; ar_hs, r_last_hs from slave side;
// grant/grant_idx mux select, busy, ar_en (ADDR phase), timeout_err (watchdog release pulse).
module axi_rd_slave_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int IDX_W          = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   ar_hs,
  input  logic                   r_last_hs,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   ar_en,
  output logic                   timeout_err
);

  // A zero timeout disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam int             WD_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  arb_state_t              state, state_n;
  logic [NUM_MASTERS-1:0]  grant_n;
  logic [IDX_W-1:0]        grant_idx_n;
  logic [IDX_W-1:0]        rr_ptr, rr_ptr_n;
  logic [WD_W-1:0]         wd_cnt, wd_cnt_n;

  logic [NUM_MASTERS-1:0]  pick;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_idx <= grant_idx_n;
      rr_ptr    <= rr_ptr_n;
      wd_cnt    <= wd_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    grant_idx_n = grant_idx;
    rr_ptr_n    = rr_ptr;
    wd_cnt_n    = wd_cnt;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        // req is only looked at here; the grant is frozen for the rest of the transaction.
        if (pick_any) begin
          state_n     = ADDR;
          grant_n     = pick;
          grant_idx_n = pick_idx;
          rr_ptr_n    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
      end
      ADDR: begin
        // r_last_hs is deliberately not looked at here, even alongside ar_hs.
        if (ar_hs) begin
          state_n  = DATA;
          wd_cnt_n = '0;
        end
      end
      DATA: begin
        if (r_last_hs) begin
          // Normal completion wins over a watchdog expiry in the same cycle.
          state_n     = IDLE;
          grant_n     = '0;
          grant_idx_n = '0;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          // Forced release; rr_ptr is left where the grant put it.
          state_n     = IDLE;
          grant_n     = '0;
          grant_idx_n = '0;
          timeout_err = 1'b1;
        end else if (wd_cnt != WD_MAX) begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        grant_n     = '0;
        grant_idx_n = '0;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign ar_en = (state == ADDR);

endmodule

// File: tb/tb_axi_rd_slave_arbiter.sv
// Directed self-checking bench for axi_rd_slave_arbiter (4 masters, 16-cycle watchdog).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_axi_rd_slave_arbiter;

  logic       ACLK;
  logic       ARESETn;
  logic [3:0] req;
  logic       ar_hs;
  logic       r_last_hs;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       ar_en;
  logic       timeout_err;

  int total;
  int bad;

  axi_rd_slave_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .req         (req),
    .ar_hs       (ar_hs),
    .r_last_hs   (r_last_hs),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .ar_en       (ar_en),
    .timeout_err (timeout_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn   = 1'b0;
    req       = '0;
    ar_hs     = 1'b0;
    r_last_hs = 1'b0;
    tick();
    tick();
    total++;
    if ({grant, grant_idx, busy, ar_en, timeout_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs: got grant=%b idx=%0d busy=%b ar_en=%b to=%b, want all 0",
               grant, grant_idx, busy, ar_en, timeout_err);
    end
    ARESETn = 1'b1;
    tick();
    total++;
    if (dut.rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    total++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2 || ar_en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: got grant=%b idx=%0d ar_en=%b busy=%b, want 0100/2/1/1",
               grant, grant_idx, ar_en, busy);
    end
    ar_hs = 1'b1;
    tick();
    ar_hs = 1'b0;
    total++;
    if (ar_en !== 1'b0 || busy !== 1'b1 || grant !== 4'b0100) begin
      bad++;
      $display("FAIL single_data: got ar_en=%b busy=%b grant=%b, want 0/1/0100", ar_en, busy, grant);
    end
    r_last_hs = 1'b1;
    tick();
    r_last_hs = 1'b0;
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || dut.rr_ptr !== 2'd3) begin
      bad++;
      $display("FAIL single_done: got grant=%b busy=%b rr_ptr=%0d, want 0000/0/3",
               grant, busy, dut.rr_ptr);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant [4];
    exp_grant[0] = 4'b1000;
    exp_grant[1] = 4'b0001;
    exp_grant[2] = 4'b0010;
    exp_grant[3] = 4'b0100;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (grant !== exp_grant[k] || grant_idx !== 2'((k + 3) % 4)) begin
        bad++;
        $display("FAIL rr_order[%0d]: got grant=%b idx=%0d, want %b idx=%0d",
                 k, grant, grant_idx, exp_grant[k], (k + 3) % 4);
      end
      ar_hs = 1'b1;
      tick();
      ar_hs     = 1'b0;
      r_last_hs = 1'b1;
      tick();
      r_last_hs = 1'b0;
      if (k == 3) req = 4'b0000;
      total++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
        bad++;
        $display("FAIL rr_release[%0d]: got busy=%b grant=%b, want 0/0000", k, busy, grant);
      end
    end
  endtask

  task automatic test_freeze();
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    total++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 || ar_en !== 1'b1) begin
      bad++;
      $display("FAIL freeze_addr: got grant=%b idx=%0d ar_en=%b, want 0001/0/1", grant, grant_idx, ar_en);
    end
    ar_hs = 1'b1;
    tick();
    ar_hs = 1'b0;
    total++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL freeze_data: got grant=%b busy=%b, want 0001/1", grant, busy);
    end
    r_last_hs = 1'b1;
    tick();
    r_last_hs = 1'b0;
    req       = 4'b0000;
    total++;
    if (grant !== 4'b0000 || dut.rr_ptr !== 2'd1) begin
      bad++;
      $display("FAIL freeze_done: got grant=%b rr_ptr=%0d, want 0000/1", grant, dut.rr_ptr);
    end
  endtask

  task automatic test_timeout();
    int early;
    req = 4'b0010;
    tick();
    req   = 4'b0000;
    ar_hs = 1'b1;
    tick();
    ar_hs = 1'b0;
    // Now in DATA cycle 1; cycles 1..15 must not flag a timeout.
    early = 0;
    for (int c = 1; c < 16; c++) begin
      if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
      tick();
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL timeout_early: got %0d bad cycles in DATA 1..15, want 0", early);
    end
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_pulse: got timeout_err=%b busy=%b on DATA cycle 16, want 1/1", timeout_err, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || grant !== 4'b0000 || dut.rr_ptr !== 2'd2) begin
      bad++;
      $display("FAIL timeout_release: got busy=%b to=%b grant=%b rr_ptr=%0d, want 0/0/0000/2",
               busy, timeout_err, grant, dut.rr_ptr);
    end
  endtask

  task automatic test_rlast_at_expiry();
    req = 4'b0100;
    tick();
    req   = 4'b0000;
    ar_hs = 1'b1;
    tick();
    ar_hs = 1'b0;
    for (int c = 1; c < 16; c++) tick();
    r_last_hs = 1'b1;
    #1;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL expiry_rlast_pulse: got timeout_err=%b, want 0", timeout_err);
    end
    tick();
    r_last_hs = 1'b0;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || dut.rr_ptr !== 2'd3) begin
      bad++;
      $display("FAIL expiry_rlast_done: got busy=%b to=%b rr_ptr=%0d, want 0/0/3",
               busy, timeout_err, dut.rr_ptr);
    end
  endtask

  task automatic test_ignore();
    ar_hs     = 1'b1;
    r_last_hs = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL ignore_idle: got busy=%b grant=%b, want 0/0000", busy, grant);
    end
    ar_hs     = 1'b0;
    r_last_hs = 1'b0;
    req       = 4'b1000;
    tick();
    req       = 4'b0000;
    ar_hs     = 1'b1;
    r_last_hs = 1'b1;
    tick();
    ar_hs     = 1'b0;
    r_last_hs = 1'b0;
    total++;
    if (busy !== 1'b1 || ar_en !== 1'b0 || grant !== 4'b1000) begin
      bad++;
      $display("FAIL ignore_addr_rlast: got busy=%b ar_en=%b grant=%b, want 1/0/1000", busy, ar_en, grant);
    end
    r_last_hs = 1'b1;
    tick();
    r_last_hs = 1'b0;
    total++;
    if (busy !== 1'b0 || dut.rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL ignore_done: got busy=%b rr_ptr=%0d, want 0/0", busy, dut.rr_ptr);
    end
  endtask

  task automatic test_reset_mid_data();
    req = 4'b0010;
    tick();
    req   = 4'b0000;
    ar_hs = 1'b1;
    tick();
    ar_hs = 1'b0;
    tick();
    ARESETn = 1'b0;
    #2;
    total++;
    if ({grant, grant_idx, busy, ar_en, timeout_err} !== 9'b0 || dut.rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_data: got grant=%b idx=%0d busy=%b ar_en=%b to=%b rr_ptr=%0d, want all 0",
               grant, grant_idx, busy, ar_en, timeout_err, dut.rr_ptr);
    end
    tick();
    ARESETn = 1'b1;
    // With rr_ptr back at 0 master 1 wins; a stale pointer of 2 would pick master 2.
    req = 4'b0110;
    tick();
    req = 4'b0000;
    total++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1 || ar_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_regrant: got grant=%b idx=%0d ar_en=%b, want 0010/1/1", grant, grant_idx, ar_en);
    end
    ar_hs = 1'b1;
    tick();
    ar_hs     = 1'b0;
    r_last_hs = 1'b1;
    tick();
    r_last_hs = 1'b0;
    req       = 4'b0001;
    tick();
    req = 4'b0000;
    total++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_req0001: got grant=%b idx=%0d, want 0001/0", grant, grant_idx);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_freeze();
    test_timeout();
    test_rlast_at_expiry();
    test_ignore();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
